// File: rtl/lcd_pkg.sv
// lcd_pkg: shared constants for the LCD clock-string generator.
//   ASCII codes used in the time field, edit-field encoding and small helpers
//   for index sizing and BCD digit rendering.
package lcd_pkg;

   localparam logic [7:0] CH_SPACE  = 8'h20;
   localparam logic [7:0] CH_COLON  = 8'h3A;
   localparam logic [7:0] CH_QMARK  = 8'h3F;
   localparam logic [7:0] CH_DIGIT0 = 8'h30;
   localparam logic [7:0] CH_A      = 8'h41;
   localparam logic [7:0] CH_P      = 8'h50;
   localparam logic [7:0] CH_M      = 8'h4D;

   localparam logic [1:0] EDIT_NONE = 2'd0;
   localparam logic [1:0] EDIT_HOUR = 2'd1;
   localparam logic [1:0] EDIT_MIN  = 2'd2;
   localparam logic [1:0] EDIT_SEC  = 2'd3;

   // Minimum index width able to address every character cell.
   function automatic int idx_w_for(input int cols, input int rows);
      return (cols * rows <= 2) ? 1 : $clog2(cols * rows);
   endfunction

   // Renders one BCD digit; anything above max is shown as '?'.
   function automatic logic [7:0] bcd_char(input logic [3:0] d, input logic [3:0] max);
      return (d > max) ? CH_QMARK : (CH_DIGIT0 + {4'h0, d});
   endfunction

endpackage

// File: rtl/lcd_hour_fmt.sv
// lcd_hour_fmt: combinational hour formatter.
//   hour_10_i/hour1_i : BCD 24h hour
//   mode_12h_i        : 1 = 12h rendering (leading zero as space), 0 = 24h
//   tens_ch_o/units_ch_o : ASCII hour characters ('?' when hour invalid)
//   pm_o              : hour >= 12
//   invalid_o         : hour not a valid BCD value in 0..23
module lcd_hour_fmt
   import lcd_pkg::*;
(
   input  logic [3:0] hour_10_i,
   input  logic [3:0] hour1_i,
   input  logic       mode_12h_i,
   output logic [7:0] tens_ch_o,
   output logic [7:0] units_ch_o,
   output logic       pm_o,
   output logic       invalid_o
);

   logic [7:0] h24;
   logic [7:0] h12;
   logic       tens12;

   always_comb begin
      invalid_o = (hour_10_i > 4'd2) || (hour1_i > 4'd9) ||
                  ((hour_10_i == 4'd2) && (hour1_i > 4'd3));
      h24  = 8'(hour_10_i) * 8'd10 + 8'(hour1_i);
      pm_o = (h24 >= 8'd12);
      // 0 -> 12 AM, 13..23 -> 1..11 PM
      if (h24 == 8'd0)       h12 = 8'd12;
      else if (h24 > 8'd12)  h12 = h24 - 8'd12;
      else                   h12 = h24;
      tens12 = (h12 >= 8'd10);

      if (mode_12h_i) begin
         tens_ch_o  = tens12 ? (CH_DIGIT0 + 8'd1) : CH_SPACE;
         units_ch_o = CH_DIGIT0 + (tens12 ? (h12 - 8'd10) : h12);
      end else begin
         tens_ch_o  = CH_DIGIT0 + {4'h0, hour_10_i};
         units_ch_o = CH_DIGIT0 + {4'h0, hour1_i};
      end

      if (invalid_o) begin
         tens_ch_o  = CH_QMARK;
         units_ch_o = CH_QMARK;
      end
   end

endmodule

// File: rtl/lcd_time_string_gen.sv
// lcd_time_string_gen: maps an LCD character index to ASCII for a COLS x ROWS
// display with an HH:MM:SS [AM|PM] field at (TIME_ROW, TIME_COL).
//   clk, rst (sync, active low)
//   req/index        : one character request per cycle, index = row*COLS+col
//   hour_10..sec1    : live BCD time (24h source)
//   mode_12h, edit_sel : display mode and field under edit (blinks)
//   out/out_valid    : registered answer, valid one cycle after req
// A request for index 0 snapshots the time/mode/edit/blink state so a whole
// frame renders one coherent time even if the counters tick mid-frame.
module lcd_time_string_gen
   import lcd_pkg::*;
#(
   parameter int COLS      = 16,
   parameter int ROWS      = 2,
   parameter int TIME_ROW  = 1,
   parameter int TIME_COL  = 0,
   parameter int IDX_W     = 5,
   parameter int BLINK_DIV = 25000000
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             req,
   input  logic [IDX_W-1:0] index,
   input  logic [3:0]       hour_10,
   input  logic [3:0]       hour1,
   input  logic [3:0]       min_10,
   input  logic [3:0]       min1,
   input  logic [3:0]       sec_10,
   input  logic [3:0]       sec1,
   input  logic             mode_12h,
   input  logic [1:0]       edit_sel,
   output logic [7:0]       out,
   output logic             out_valid
);

   localparam int               CNT_W = (BLINK_DIV > 2) ? $clog2(BLINK_DIV) : 1;
   localparam logic [IDX_W:0]   BASE  = (IDX_W+1)'(TIME_ROW * COLS + TIME_COL);
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(BLINK_DIV - 1);

   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             blink_q, blink_d;
   logic [3:0]       fr_h10_q, fr_h1_q, fr_m10_q, fr_m1_q, fr_s10_q, fr_s1_q;
   logic             fr_mode_q, fr_blink_q;
   logic [1:0]       fr_edit_q;
   logic [7:0]       out_q, ch_d;
   logic             vld_q;

   // Index 0 answers from live inputs (it is the one that loads the frame).
   logic       use_live;
   logic [3:0] s_h10, s_h1, s_m10, s_m1, s_s10, s_s1;
   logic       s_mode, s_blink;
   logic [1:0] s_edit;

   assign use_live = (index == '0);
   assign s_h10   = use_live ? hour_10  : fr_h10_q;
   assign s_h1    = use_live ? hour1    : fr_h1_q;
   assign s_m10   = use_live ? min_10   : fr_m10_q;
   assign s_m1    = use_live ? min1     : fr_m1_q;
   assign s_s10   = use_live ? sec_10   : fr_s10_q;
   assign s_s1    = use_live ? sec1     : fr_s1_q;
   assign s_mode  = use_live ? mode_12h : fr_mode_q;
   assign s_edit  = use_live ? edit_sel : fr_edit_q;
   assign s_blink = use_live ? blink_q  : fr_blink_q;

   logic [7:0] hr_tens, hr_units;
   logic       hr_pm, hr_inv;

   lcd_hour_fmt u_hour (
      .hour_10_i  (s_h10),
      .hour1_i    (s_h1),
      .mode_12h_i (s_mode),
      .tens_ch_o  (hr_tens),
      .units_ch_o (hr_units),
      .pm_o       (hr_pm),
      .invalid_o  (hr_inv)
   );

   // Address decode relative to the start of the time field.
   logic [IDX_W:0] widx, rel;
   logic           in_field;
   logic [3:0]     off;
   logic           blank_h, blank_m, blank_s;

   assign widx     = {1'b0, index};
   assign rel      = widx - BASE;
   assign in_field = (widx >= BASE) && (rel < (IDX_W+1)'(11));
   assign off      = rel[3:0];
   assign blank_h  = (s_edit == EDIT_HOUR) && !s_blink;
   assign blank_m  = (s_edit == EDIT_MIN)  && !s_blink;
   assign blank_s  = (s_edit == EDIT_SEC)  && !s_blink;

   always_comb begin
      ch_d = CH_SPACE;
      if (in_field) begin
         case (off)
            4'd0:       ch_d = blank_h ? CH_SPACE : hr_tens;
            4'd1:       ch_d = blank_h ? CH_SPACE : hr_units;
            4'd2, 4'd5: ch_d = CH_COLON;
            4'd3:       ch_d = blank_m ? CH_SPACE : bcd_char(s_m10, 4'd5);
            4'd4:       ch_d = blank_m ? CH_SPACE : bcd_char(s_m1, 4'd9);
            4'd6:       ch_d = blank_s ? CH_SPACE : bcd_char(s_s10, 4'd5);
            4'd7:       ch_d = blank_s ? CH_SPACE : bcd_char(s_s1, 4'd9);
            // An invalid hour makes the A/P letter unknowable; 'M' stays.
            4'd9:       if (s_mode) ch_d = hr_inv ? CH_QMARK : (hr_pm ? CH_P : CH_A);
            4'd10:      if (s_mode) ch_d = CH_M;
            default:    ch_d = CH_SPACE;
         endcase
      end
   end

   // Free-running blink timebase, independent of requests.
   always_comb begin
      cnt_d   = cnt_q + CNT_W'(1);
      blink_d = blink_q;
      if (cnt_q == CNT_MAX) begin
         cnt_d   = '0;
         blink_d = ~blink_q;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         cnt_q      <= '0;
         blink_q    <= 1'b1;
         fr_h10_q   <= '0;
         fr_h1_q    <= '0;
         fr_m10_q   <= '0;
         fr_m1_q    <= '0;
         fr_s10_q   <= '0;
         fr_s1_q    <= '0;
         fr_mode_q  <= 1'b0;
         fr_edit_q  <= EDIT_NONE;
         fr_blink_q <= 1'b1;
         out_q      <= 8'h00;
         vld_q      <= 1'b0;
      end else begin
         cnt_q   <= cnt_d;
         blink_q <= blink_d;
         vld_q   <= req;
         if (req) begin
            out_q <= ch_d;
            if (use_live) begin
               fr_h10_q   <= hour_10;
               fr_h1_q    <= hour1;
               fr_m10_q   <= min_10;
               fr_m1_q    <= min1;
               fr_s10_q   <= sec_10;
               fr_s1_q    <= sec1;
               fr_mode_q  <= mode_12h;
               fr_edit_q  <= edit_sel;
               fr_blink_q <= blink_q;
            end
         end
      end
   end

   assign out       = out_q;
   assign out_valid = vld_q;

endmodule

// File: tb/tb_lcd_time_string_gen.sv
module tb_lcd_time_string_gen;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       req = 1'b0;
   logic [4:0] index = '0;
   logic [3:0] hour_10 = '0, hour1 = '0, min_10 = '0, min1 = '0, sec_10 = '0, sec1 = '0;
   logic       mode_12h = 1'b0;
   logic [1:0] edit_sel = 2'd0;
   logic [7:0] out;
   logic       out_valid;

   lcd_time_string_gen #(
      .COLS(16), .ROWS(2), .TIME_ROW(1), .TIME_COL(0), .IDX_W(5), .BLINK_DIV(4)
   ) dut (
      .clk(clk), .rst(rst), .req(req), .index(index),
      .hour_10(hour_10), .hour1(hour1), .min_10(min_10), .min1(min1),
      .sec_10(sec_10), .sec1(sec1), .mode_12h(mode_12h), .edit_sel(edit_sel),
      .out(out), .out_valid(out_valid)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // Reference blink phase: toggles every 4 cycles, visible (1) after reset.
   int mcnt = 0;
   bit mph = 1'b1;
   always @(posedge clk) begin
      if (!rst) begin
         mcnt <= 0;
         mph  <= 1'b1;
      end else if (mcnt == 3) begin
         mcnt <= 0;
         mph  <= ~mph;
      end else begin
         mcnt <= mcnt + 1;
      end
   end

   typedef struct {
      int         idx;
      logic [7:0] ch;
      int         cyc;
   } exp_t;

   exp_t q[$];
   exp_t mon_e;
   int   checks = 0;
   int   failures = 0;

   // Monitor: every valid output must match the oldest outstanding request,
   // exactly one cycle after it was issued.
   always @(negedge clk) begin
      if (out_valid === 1'b1) begin
         checks++;
         if (q.size() == 0) begin
            failures++;
            $display("FAIL unexpected_valid out=%h", out);
         end else begin
            mon_e = q.pop_front();
            if (out !== mon_e.ch || cyc != mon_e.cyc) begin
               failures++;
               $display("FAIL idx%0d out=%h cyc=%0d expected %h cyc=%0d",
                        mon_e.idx, out, cyc, mon_e.ch, mon_e.cyc);
            end
         end
      end
   end

   task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s got=%h expected=%h", name, act, exp);
      end
   endtask

   task automatic set_time(input logic [3:0] a, b, c, d, e, f);
      hour_10 = a; hour1 = b; min_10 = c; min1 = d; sec_10 = e; sec1 = f;
   endtask

   // Row 1 holds the time field; row 0 and out-of-range indices are spaces.
   function automatic logic [7:0] exp_ch(input string row, input int idx);
      if (idx >= 16 && idx < 32) return 8'(row[idx-16]);
      return 8'h20;
   endfunction

   task automatic issue(input int idx, input logic [7:0] ch);
      exp_t e;
      req   = 1'b1;
      index = 5'(idx);
      if (rst) begin
         e.idx = idx; e.ch = ch; e.cyc = cyc + 1;
         q.push_back(e);
      end
      @(posedge clk); #1;
      req = 1'b0;
   endtask

   task automatic frame(input string row);
      for (int i = 0; i < 32; i++) issue(i, exp_ch(row, i));
   endtask

   task automatic idle(input int n);
      repeat (n) begin @(posedge clk); #1; end
   endtask

   bit seen0, seen1;
   bit ph;

   initial begin
      // Reset with req held: nothing may come out.
      req = 1'b1; index = 5'd16;
      idle(3);
      chk("reset_out", out, 8'h00);
      chk("reset_valid", {7'b0, out_valid}, 8'h00);
      req = 1'b0;
      rst = 1'b1;
      idle(1);

      // 24h and 12h rendering.
      set_time(4'd1, 4'd3, 4'd0, 4'd5, 4'd0, 4'd9);
      mode_12h = 1'b0;
      frame("13:05:09        ");
      mode_12h = 1'b1;
      frame(" 1:05:09 PM     ");
      set_time(4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0);
      frame("12:00:00 AM     ");
      set_time(4'd1, 4'd2, 4'd0, 4'd0, 4'd0, 4'd0);
      frame("12:00:00 PM     ");

      // Snapshot coherence: inputs tick right after index 0.
      mode_12h = 1'b0;
      set_time(4'd1, 4'd2, 4'd5, 4'd9, 4'd5, 4'd9);
      issue(0, 8'h20);
      set_time(4'd1, 4'd3, 4'd0, 4'd0, 4'd0, 4'd0);
      for (int i = 1; i < 32; i++) issue(i, exp_ch("12:59:59        ", i));
      frame("13:00:00        ");

      // Gapped requests: valid drops, out holds.
      issue(16, 8'h31);
      idle(1);
      chk("gap1_valid", {7'b0, out_valid}, 8'h00);
      chk("gap1_hold", out, 8'h31);
      idle(1);
      chk("gap2_hold", out, 8'h31);
      issue(23, 8'h30);
      idle(1);
      chk("gap3_valid", {7'b0, out_valid}, 8'h00);
      chk("gap3_hold", out, 8'h30);

      // Blink: 36-cycle frame spacing alternates the starting phase.
      set_time(4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6);
      edit_sel = 2'd2;
      seen0 = 0; seen1 = 0;
      repeat (4) begin
         idle(4);
         ph = mph;
         if (ph) seen1 = 1; else seen0 = 1;
         frame(ph ? "12:34:56        " : "12:  :56        ");
      end
      chk("blink_both_phases", {6'b0, seen1, seen0}, 8'h03);
      edit_sel = 2'd1;
      ph = mph;
      frame(ph ? "12:34:56        " : "  :34:56        ");
      idle(4);
      edit_sel = 2'd3;
      ph = mph;
      frame(ph ? "12:34:56        " : "12:34:          ");
      edit_sel = 2'd0;
      frame("12:34:56        ");
      idle(4);
      frame("12:34:56        ");

      // Invalid hour and minute digit.
      set_time(4'd2, 4'd7, 4'd0, 4'hA, 4'd0, 4'd0);
      frame("??:0?:00        ");
      mode_12h = 1'b1;
      for (int i = 0; i < 26; i++) issue(i, exp_ch("??:0?:00 ?      ", i));

      // Reset mid-frame with req held.
      mode_12h = 1'b0;
      set_time(4'd0, 4'd9, 4'd4, 4'd5, 4'd3, 4'd0);
      for (int i = 0; i < 5; i++) issue(i, 8'h20);
      rst = 1'b0;
      issue(5, 8'h20);
      chk("midreset_out", out, 8'h00);
      chk("midreset_valid", {7'b0, out_valid}, 8'h00);
      rst = 1'b1;
      frame("09:45:30        ");

      // Drain the scoreboard with a bounded wait.
      for (int i = 0; i < 10 && q.size() != 0; i++) idle(1);
      checks++;
      if (q.size() != 0) begin
         failures++;
         $display("FAIL drain outstanding=%0d expected=0", q.size());
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/lcd_time_string_gen.md
Name: lcd_time_string_gen

Overview:
Parametrised successor to the fixed 16x2 clock-string generator. It maps an LCD character index to an ASCII code for a COLS x ROWS character display, placing an HH:MM:SS field at a configurable row and column. It adds 12/24-hour display, AM/PM, blinking of the field being edited, a per-frame time snapshot to prevent tearing, and a req/valid handshake. It sits between the BCD timekeeping counters and the LCD write sequencer, which requests one index per character write.

Parameters:
COLS, 16, characters per display row (>=11)
ROWS, 2, display rows
TIME_ROW, 1, row holding the time field (0..ROWS-1)
TIME_COL, 0, first column of the time field; TIME_COL+11 <= COLS is required
IDX_W, 5, index width; 2**IDX_W >= COLS*ROWS
BLINK_DIV, 25000000, clk cycles per blink half-period (>=2)

Ports:
clk  in  1  system clock, all state on rising edge
rst  in  1  synchronous active-low reset
req  in  1  character request strobe, one cycle per index
index  in  IDX_W  character position; row*COLS+col
hour_10  in  4  BCD hours tens (24h source)
hour1  in  4  BCD hours units
min_10  in  4  BCD minutes tens
min1  in  4  BCD minutes units
sec_10  in  4  BCD seconds tens
sec1  in  4  BCD seconds units
mode_12h  in  1  1 = 12h display with AM/PM, 0 = 24h
edit_sel  in  2  field under edit: 0 none, 1 hour, 2 min, 3 sec
out  out  8  ASCII character
out_valid  out  1  out holds the answer to the previous-cycle req

Behaviour:
- Reset (rst low at a clk edge): out=8'h00, out_valid=0, snapshot registers=0, blink counter=0, blink_phase=1 (visible), frame_phase=1. Reset mid-frame discards the frame; the next index-0 request starts a fresh one.
- Latency 1: req high in cycle n -> out/out_valid updated at edge n+1. Without req: out_valid=0 and out holds its last value. Back-to-back reqs give one result per cycle.
- Snapshot: req with index==0 loads all six BCD inputs, mode_12h, edit_sel and blink_phase into frame registers. The lookup for that same request uses the live values. All other requests use the frame registers. The whole frame is therefore coherent even if seconds roll over mid-frame.
- Blink counter runs freely 0..BLINK_DIV-1 and toggles blink_phase on wrap. It is independent of req.
- Layout relative to base=TIME_ROW*COLS+TIME_COL:
  - +0 hour tens, +1 hour units, +2 ':' (0x3A)
  - +3 min tens, +4 min units, +5 ':'
  - +6 sec tens, +7 sec units
  - +8 space
  - +9 'A'(0x41) or 'P'(0x50), +10 'M'(0x4D) in 12h mode; spaces in 24h mode
- Every other index, including index >= COLS*ROWS, returns 0x20.
- Digits: valid BCD d -> 0x30+d. A digit >9, min_10/sec_10 >5, or hour >23 -> '?' (0x3F) for the affected digit(s). Hour invalid -> both hour digits and AM/PM show '?'.
- 12h conversion from 24h hour h:
  - h=0 -> 12 AM
  - 1..11 -> h AM
  - 12 -> 12 PM
  - 13..23 -> h-12 PM
  - Leading hour-tens zero shows space (0x20) in 12h; shows '0' in 24h.
- Blink: when frame edit_sel selects a field and frame blink_phase=0, both digits of that field read 0x20. Colons and AM/PM never blink. edit_sel=0 means always visible.
- req asserted during reset is ignored.

Decomposition:
- Package lcd_pkg: ASCII constants (SPACE, COLON, QMARK, DIGIT0, 'A','P','M'), edit_sel encoding, and an IDX_W helper function.
- Sub-module lcd_hour_fmt (combinational): BCD 24h hour + mode_12h -> two ASCII hour characters, AM/PM flag, invalid flag. Instantiated once.
- Top module holds the snapshot, blink counter, address decode and output register.

Test Plan:
- Reset, then req index 0..31 with 13:05:09, 24h, COLS=16, TIME_ROW=1, TIME_COL=0 -> idx16..23 = 31 33 3A 30 35 3A 30 39; all others 20; out_valid one cycle after each req.
- Same time with mode_12h=1 -> idx16..17 = 20 31; idx25..26 = 50 4D; at 00:00:00 -> 31 32 ... 41 4D; at 12:00:00 -> 31 32 ... 50 4D.
- Start frame at 12:59:59 and change inputs to 13:00:00 after index 0 -> remaining indices still read 12:59:59; the next frame reads 13:00:00.
- BLINK_DIV=4, edit_sel=2: frames started in phase 0 -> idx19,20 = 20 20 and idx18 = 3A; frames started in phase 1 -> digits shown; edit_sel=0 -> never blanked.
- hour_10=2, hour1=7, min1=4'hA -> idx16,17 = 3F 3F, idx20 = 3F, and in 12h mode idx25 = 3F.
- Assert rst mid-frame with req held -> out=00, out_valid=0 on the next edge; resume at index 0 gives correct output; gapped reqs -> out_valid low in the gaps and out held.
